// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI register slave
package spi_pkg;

    localparam int ADDR_WIDTH    = 3;
    localparam int DATA_WIDTH    = 8;
    localparam int MIN_SCLK_HALF = 4;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/spi_reg_slave_if.sv
// rtl/spi_reg_slave_if.sv - SPI pins plus local register write/read ports
interface spi_reg_slave_if #(
    parameter int ADDR_WIDTH = spi_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = spi_pkg::DATA_WIDTH
);

    logic                  sclk;
    logic                  cs;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic                  reg_wr_valid;
    logic [ADDR_WIDTH-1:0] reg_wr_addr;
    logic [DATA_WIDTH-1:0] reg_wr_data;
    logic [ADDR_WIDTH-1:0] reg_rd_addr;
    logic [DATA_WIDTH-1:0] reg_rd_data;
    logic                  frame_err;

    modport slave (
        input  sclk, cs, mosi, reg_rd_addr,
        output miso, miso_oe, reg_wr_valid, reg_wr_addr, reg_wr_data,
               reg_rd_data, frame_err
    );

    modport master (
        output sclk, cs, mosi, reg_rd_addr,
        input  miso, miso_oe, reg_wr_valid, reg_wr_addr, reg_wr_data,
               reg_rd_data, frame_err
    );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop pin synchronizer with rise/fall pulses
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // shift the pin through the chain; remember the last synced level for edge detect
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // chain resets low so a pin held low through reset never looks like a new edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // edge pulses are one clk wide and derived only from flops
    always_comb begin
        level = sync_q[SYNC_STAGES-1];
        rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall  = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

endmodule

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - oversampled SPI slave with an 8-entry register bank
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH  = spi_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = spi_pkg::DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_reg_slave_if.slave   bus
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int CMD_BITS = 1 + ADDR_WIDTH;
    localparam int CNT_W    = $clog2(DATA_WIDTH + 1);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise_unused, cs_fall_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(bus.sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .din(bus.cs),
        .level(cs_s), .rise(cs_rise_unused), .fall(cs_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(bus.mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  miso_q, miso_d;
    logic                  armed_q, armed_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0] bank_q [DEPTH];
    logic [DATA_WIDTH-1:0] bank_d [DEPTH];

    logic [CMD_BITS-1:0]   cmd_word;
    logic                  abort;
    logic                  miso_oe_c;

    // command word as it will look once the current mosi bit is shifted in; abort is cs high mid-frame
    always_comb begin
        cmd_word = {rx_q[CMD_BITS-2:0], mosi_s};
        abort    = cs_s && (state_q == ST_CMD || state_q == ST_WDATA || state_q == ST_RDATA);
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            armed_q     <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            armed_q     <= armed_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // next-state logic; cs high mid-frame beats any sclk edge in the same clk
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!cs_s && armed_q) state_d = ST_CMD;
            ST_CMD: begin
                if (abort) state_d = ST_IDLE;
                else if (sclk_rise && bit_cnt_q == CNT_W'(CMD_BITS - 1))
                    state_d = (cmd_word[CMD_BITS-1] == RW_WRITE) ? ST_WDATA : ST_RDATA;
            end
            ST_WDATA: begin
                if (abort) state_d = ST_IDLE;
                else if (bit_cnt_q == CNT_W'(DATA_WIDTH)) state_d = ST_DONE;
            end
            ST_RDATA: begin
                if (abort) state_d = ST_IDLE;
                else if (sclk_rise && bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = ST_DONE;
            end
            ST_DONE:  if (cs_s) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // shift registers, counters and the write-commit pulse
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        armed_d     = armed_q | cs_s;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = abort;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                miso_d    = 1'b0;
            end
            ST_CMD: begin
                if (!abort && sclk_rise) begin
                    rx_d      = {rx_q[DATA_WIDTH-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        // read data is snapshotted here so later writes cannot disturb it
                        addr_d    = cmd_word[ADDR_WIDTH-1:0];
                        tx_d      = bank_q[cmd_word[ADDR_WIDTH-1:0]];
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_WDATA: begin
                if (!abort) begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH)) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = rx_q;
                    end else if (sclk_rise) begin
                        rx_d      = {rx_q[DATA_WIDTH-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RDATA: begin
                if (abort) begin
                    miso_d = 1'b0;
                end else begin
                    if (sclk_fall) begin
                        miso_d = tx_q[DATA_WIDTH-1];
                        tx_d   = tx_q << 1;
                    end
                    if (sclk_rise) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: miso_d = 1'b0;
            default: miso_d = 1'b0;
        endcase
    end

    // bank commit lands one clk after the strobe rises, so the strobe clk still reads the old value
    always_comb begin
        bank_d = bank_q;
        if (wr_valid_q) bank_d[wr_addr_q] = wr_data_q;
    end

    // register bank storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bank_q <= '{default: '0};
        else     bank_q <= bank_d;
    end

    // outputs: miso is driven only in the read data phase and releases as soon as cs is seen high
    always_comb begin
        miso_oe_c = (state_q == ST_RDATA) && !cs_s;
    end

    assign bus.miso         = miso_oe_c & miso_q;
    assign bus.miso_oe      = miso_oe_c;
    assign bus.reg_wr_valid = wr_valid_q;
    assign bus.reg_wr_addr  = wr_addr_q;
    assign bus.reg_wr_data  = wr_data_q;
    assign bus.reg_rd_data  = bank_q[bus.reg_rd_addr];
    assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - directed and randomized bench for spi_reg_slave
module tb_spi_reg_slave;
    import spi_pkg::*;

    localparam int HALF = MIN_SCLK_HALF + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_reg_slave_if bus ();
    spi_reg_slave dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  bank_m [8];
    logic [10:0] wr_log [$];
    int          err_cnt = 0;
    logic [7:0]  rd_at_commit = '0;
    logic [7:0]  rd_after_commit = '0;
    logic        commit_prev = 1'b0;

    always @(negedge clk) begin
        if (commit_prev) rd_after_commit = bus.reg_rd_data;
        commit_prev = 1'b0;
        if (!rst && bus.reg_wr_valid) begin
            wr_log.push_back({bus.reg_wr_addr, bus.reg_wr_data});
            rd_at_commit = bus.reg_rd_data;
            commit_prev  = 1'b1;
        end
        if (!rst && bus.frame_err) err_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m, output logic oe);
        bus.mosi = b;
        clks(HALF);
        m  = bus.miso;
        oe = bus.miso_oe;
        bus.sclk = 1'b1;
        clks(HALF);
        bus.sclk = 1'b0;
    endtask

    task automatic cs_begin();
        bus.cs = 1'b0;
        clks(HALF);
    endtask

    task automatic cs_end(input int gap);
        clks(HALF);
        bus.cs = 1'b1;
        clks(gap);
    endtask

    task automatic spi_write(input logic [2:0] a, input logic [7:0] d, input int extra, output int oe_hits);
        logic [11:0] w;
        logic m, oe;
        w = {RW_WRITE, a, d};
        oe_hits = 0;
        cs_begin();
        for (int i = 11; i >= 0; i--) begin
            spi_bit(w[i], m, oe);
            if (oe) oe_hits++;
        end
        for (int i = 0; i < extra; i++) begin
            spi_bit(1'($urandom_range(0, 1)), m, oe);
            if (oe) oe_hits++;
        end
        cs_end(20);
    endtask

    task automatic spi_read(input logic [2:0] a, input int delay, output logic [7:0] data,
                            output int cmd_oe_hits, output int data_oe_miss);
        logic [3:0] c;
        logic m, oe;
        c = {RW_READ, a};
        data = '0;
        cmd_oe_hits = 0;
        data_oe_miss = 0;
        cs_begin();
        for (int i = 3; i >= 0; i--) begin
            spi_bit(c[i], m, oe);
            if (oe) cmd_oe_hits++;
        end
        clks(delay);
        for (int i = 0; i < 8; i++) begin
            spi_bit(1'($urandom_range(0, 1)), m, oe);
            data = {data[6:0], m};
            if (!oe) data_oe_miss++;
        end
        cs_end(20);
    endtask

    task automatic expect_write(input string tag, input logic [2:0] a, input logic [7:0] d);
        check({tag, "_wr_count"}, wr_log.size(), 1);
        if (wr_log.size() > 0) check({tag, "_wr_entry"}, wr_log[0], {a, d});
        wr_log.delete();
        bank_m[a] = d;
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.reg_rd_addr = 3'(i);
            #1;
            check($sformatf("%s_bank%0d", tag, i), bus.reg_rd_data, bank_m[i]);
        end
    endtask

    initial begin
        int         oeh, cmd_oe, data_miss;
        logic [7:0] rd;
        logic [2:0] a;
        logic [7:0] d;
        logic       m, oe;
        logic [6:0] ab;

        for (int i = 0; i < 8; i++) bank_m[i] = '0;
        rst = 1'b1;
        bus.sclk = 1'b0;
        bus.cs = 1'b1;
        bus.mosi = 1'b0;
        bus.reg_rd_addr = '0;
        clks(3);
        check("rst_miso", bus.miso, 0);
        check("rst_miso_oe", bus.miso_oe, 0);
        check("rst_wr_valid", bus.reg_wr_valid, 0);
        check("rst_wr_addr", bus.reg_wr_addr, 0);
        check("rst_wr_data", bus.reg_wr_data, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check_bank("rst");
        rst = 1'b0;
        clks(5);

        // write addr 5 = 0xEA, with a read-while-commit check on the same address
        bus.reg_rd_addr = 3'd5;
        spi_write(3'd5, 8'hEA, 0, oeh);
        expect_write("w5", 3'd5, 8'hEA);
        check("w5_old_at_commit", rd_at_commit, 8'h00);
        check("w5_new_after_commit", rd_after_commit, 8'hEA);
        check("w5_rd_port", bus.reg_rd_data, 8'hEA);
        check("w5_oe_hits", oeh, 0);
        check("w5_frame_err", err_cnt, 0);

        // read after write with a long idle before the data phase
        spi_write(3'd2, 8'h5D, 0, oeh);
        expect_write("w2", 3'd2, 8'h5D);
        spi_read(3'd2, 200, rd, cmd_oe, data_miss);
        check("r2_data", rd, 8'h5D);
        check("r2_cmd_oe", cmd_oe, 0);
        check("r2_data_oe_miss", data_miss, 0);
        check("r2_no_write", wr_log.size(), 0);
        check("r2_oe_after", bus.miso_oe, 0);

        // abort a write after 3 data bits
        ab = 7'b1011101;
        cs_begin();
        for (int i = 6; i >= 0; i--) spi_bit(ab[i], m, oe);
        cs_end(20);
        check("abort_frame_err", err_cnt, 1);
        check("abort_no_write", wr_log.size(), 0);
        bus.reg_rd_addr = 3'd3;
        #1;
        check("abort_bank3", bus.reg_rd_data, 8'h00);

        // reset during the 4th data bit of a read of addr 5
        cs_begin();
        for (int i = 3; i >= 0; i--) spi_bit(((4'b0101 >> i) & 4'd1) != 0, m, oe);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, m, oe);
        bus.mosi = 1'b0;
        clks(2);
        rst = 1'b1;
        clks(1);
        check("mrst_miso", bus.miso, 0);
        check("mrst_miso_oe", bus.miso_oe, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) bank_m[i] = '0;
        check_bank("mrst");
        clks(2);
        bus.sclk = 1'b1;
        clks(HALF);
        bus.sclk = 1'b0;
        oeh = 0;
        for (int i = 0; i < 8; i++) begin
            spi_bit(1'b1, m, oe);
            if (oe) oeh++;
        end
        cs_end(20);
        check("mrst_tail_oe", oeh, 0);
        check("mrst_tail_no_write", wr_log.size(), 0);
        check("mrst_tail_no_err", err_cnt, 1);
        spi_write(3'd1, 8'hA5, 0, oeh);
        expect_write("w1", 3'd1, 8'hA5);
        check_bank("after_mrst");

        // back-to-back write then read of addr 7
        spi_write(3'd7, 8'h3C, 0, oeh);
        expect_write("w7", 3'd7, 8'h3C);
        spi_read(3'd7, 0, rd, cmd_oe, data_miss);
        check("r7_data", rd, 8'h3C);
        check("r7_data_oe_miss", data_miss, 0);
        check("b2b_frame_err", err_cnt, 1);

        // overlong write frame
        d = 8'($urandom);
        spi_write(3'd4, d, 4, oeh);
        expect_write("wlong", 3'd4, d);

        // random mix of frames against the bank model
        for (int k = 0; k < 14; k++) begin
            a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                spi_write(a, d, $urandom_range(0, 2), oeh);
                expect_write($sformatf("rnd%0d_w", k), a, d);
            end else begin
                spi_read(a, $urandom_range(0, 40), rd, cmd_oe, data_miss);
                check($sformatf("rnd%0d_r", k), rd, bank_m[a]);
                check($sformatf("rnd%0d_oe", k), data_miss + cmd_oe, 0);
            end
        end
        check_bank("final");
        check("final_frame_err", err_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI slave register file that sits directly downstream of the spi_fsm master.
- Consumes sclk/cs/mosi and drives miso.
- Decodes the 12-bit frame {rw, addr[2:0], data[7:0]} and holds an 8 x 8-bit register bank.
- Exposes a write-strobe port and a parallel read port to local logic; all logic runs in the system clk domain by oversampling the SPI pins.

Parameters:
- ADDR_WIDTH, 3, register address bits; bank depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, register and SPI data bits.
- CMD_BITS, 1+ADDR_WIDTH, rw flag plus address bits, shifted first.
- SYNC_STAGES, 2, synchronizer flops per SPI input pin.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from master; CPOL=0, CPHA=0.
- cs  in  1  chip select, active-low.
- mosi  in  1  master-out data, MSB first.
- miso  out  1  slave-out data, MSB first.
- miso_oe  out  1  miso drive enable; 1 only during the read data phase.
- reg_wr_valid  out  1  one-clk pulse on each committed SPI write.
- reg_wr_addr  out  ADDR_WIDTH  address of the committed write.
- reg_wr_data  out  DATA_WIDTH  data of the committed write.
- reg_rd_addr  in  ADDR_WIDTH  local combinational read address.
- reg_rd_data  out  DATA_WIDTH  bank[reg_rd_addr], combinational.
- frame_err  out  1  one-clk pulse when cs rises before a frame completes.

Behaviour:
- Reset values: miso=0, miso_oe=0, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, frame_err=0, all bank entries 0, state IDLE, bit counter 0.
- Input synchronization: sclk, cs and mosi each pass through SYNC_STAGES flops, followed by an edge detect. A pin edge is seen SYNC_STAGES+1 clks after it occurs.
- Supported timing: sclk high and low phases of at least 4 clk each. The master's 10-clk sclk period is supported.
- Bits are sampled from synced mosi on each detected sclk rise. miso changes only on a detected sclk fall.
- States and transitions:
  - IDLE: wait for synced cs low, then go to CMD with the bit count cleared.
  - CMD: shift CMD_BITS bits.
    - After the 4th rise with rw=1, go to WDATA.
    - After the 4th rise with rw=0, latch bank[addr] into the tx shift register and go to RDATA.
  - WDATA: shift 8 bits. On the 8th rise, in the next clk, write bank[addr] and pulse reg_wr_valid with reg_wr_addr/reg_wr_data. Then go to DONE.
  - RDATA:
    - miso_oe=1.
    - miso = tx MSB, driven from the first sclk fall after entering RDATA.
    - The tx register shifts left on each subsequent fall; 8 bits total.
    - The master may idle sclk low for any time (its delay phase); miso holds its value while sclk is idle.
    - After the 8th rise, go to DONE.
  - DONE: ignore all further sclk edges until cs is high. miso_oe=0 and miso=0 in every state except RDATA.
- Synced cs high in any state other than IDLE or DONE:
  - Return to IDLE and pulse frame_err.
  - No register write occurs.
  - miso_oe drops in the same clk.
- Synced cs high in DONE returns to IDLE with no frame_err.
- Simultaneous events:
  - A cs rise detected in the same clk as an sclk edge takes priority; the edge is ignored.
  - A local read of the address being written returns the old value in the commit clk and the new value from the next clk.
- Read data is a snapshot taken at address decode; a later write does not alter a read in progress.
- Reset mid-frame: everything returns to its reset value at once. The rest of the current frame is ignored until cs has been seen high and then low again.
- Bit and address counters never wrap inside a frame; extra bits are absorbed in DONE.

Decomposition:
- Package spi_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - RW_WRITE=1'b1 and RW_READ=1'b0.
  - State encoding: IDLE=0, CMD=1, WDATA=2, RDATA=3, DONE=4.
  - MIN_SCLK_HALF=4.
- Sub-module spi_sync_edge contains the SYNC_STAGES flop chain plus rise/fall pulse outputs. It is instantiated for sclk, cs and mosi; for mosi only the level output is used.

Test Plan:
- Write frame: cs low, send {1,101,11101010} at a 10-clk sclk period. Expect exactly one reg_wr_valid pulse with addr=5, data=0xEA; reg_rd_addr=5 then returns 0xEA; frame_err stays 0.
- Read after write:
  - Write 0x5D to addr 2.
  - Send {0,010}, hold sclk low for 200 clks, then clock 8 bits.
  - Master samples 0,1,0,1,1,1,0,1 on miso; miso_oe is high only in the data phase; no write pulse occurs.
- Abort: send {1,011} plus 3 data bits, then raise cs. Expect a frame_err pulse, no reg_wr_valid, and bank[3] still 0.
- Reset mid-read: assert rst during the 4th read data bit. Expect miso=0, miso_oe=0 and all registers 0. After cs toggles high then low, the next write frame {1,001,0xA5} commits correctly.
- Back-to-back frames with cs high for 20 clks between them: write addr 7 = 0x3C, then read addr 7. Read returns 0x3C; no frame_err.
- Overlong frame: a write frame with 4 extra sclk pulses. Expect exactly one commit of the first 8 data bits; the extra bits are ignored.
